// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared types for the 8-bit accumulator CPU: instruction field widths,
//   the opcode and sequencer-phase enumerations, and the ALU-opcode helper
//   used by both the controller and the ALU.
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned OPC_W = 3;  // opcode field of the instruction word
  localparam int unsigned PH_W  = 3;  // eight sequencer phases

  typedef enum logic [OPC_W-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [PH_W-1:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  // Opcodes whose result is written back into the accumulator and which
  // therefore need the operand read from memory.
  function automatic logic is_aluop(input opcode_e op);
    return op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
  endfunction

endpackage : cpu_pkg

// File: rtl/cpu_controller.sv
// ----------------------------------------------------------------------------
// cpu_controller
//   Eight-phase instruction sequencer. A free-running phase counter walks
//   every instruction through fetch (phases 0-3) and execute (phases 4-7);
//   the strobes below are pure combinational decodes of the phase, the halt
//   flag, the IR opcode and the ALU zero flag, so each strobe is valid in
//   the same cycle as its phase.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   opcode   in   IR opcode field
//   zero     in   accumulator-is-zero flag
//   sel      out  memory address mux: 1 = PC, 0 = IR operand address
//   rd       out  memory read enable
//   wr       out  memory write strobe
//   load_ir  out  instruction register load
//   load_pc  out  program counter parallel load from IR address
//   inc_pc   out  program counter increment
//   load_ac  out  accumulator load
//   data_e   out  accumulator drives the data bus
//   halt     out  CPU halted
//   phase    out  current phase (debug)
// ----------------------------------------------------------------------------
module cpu_controller
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  output logic             sel,
  output logic             rd,
  output logic             wr,
  output logic             load_ir,
  output logic             load_pc,
  output logic             inc_pc,
  output logic             load_ac,
  output logic             data_e,
  output logic             halt,
  output logic [PH_W-1:0]  phase
);

  phase_e  phase_q, phase_d;
  logic    halted_q, halted_d;
  opcode_e op;
  logic    aluop;

  assign op    = opcode_e'(opcode);
  assign aluop = is_aluop(op);

  // --------------------------------------------------------------------------
  // Next state: the phase advances every cycle and wraps 7 -> 0. A HLT seen
  // in OP_ADDR freezes the counter at OP_ADDR and latches the halt flag;
  // from then on only reset moves the sequencer.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (phase_q == PH_OP_ADDR && op == OP_HLT) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_e'(phase_q + 3'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // --------------------------------------------------------------------------
  // Strobe decode. Phases 0-3 ignore opcode/zero because the IR is still
  // being loaded. Once halted, only halt is asserted.
  // --------------------------------------------------------------------------
  always_comb begin
    sel     = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    load_ir = 1'b0;
    load_pc = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    data_e  = 1'b0;
    halt    = 1'b0;

    if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (phase_q)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel     = 1'b1;
          rd      = 1'b1;
          load_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          // The PC steps past the instruction here, unless it is HLT.
          halt   = (op == OP_HLT);
          inc_pc = (op != OP_HLT);
        end
        PH_OP_FETCH: begin
          rd = aluop;
        end
        PH_ALU_OP: begin
          // SKZ skips by issuing a second increment when the ACC is zero.
          rd      = aluop;
          inc_pc  = (op == OP_SKZ) && zero;
          load_pc = (op == OP_JMP);
          data_e  = (op == OP_STO);
        end
        PH_STORE: begin
          // data_e is held across both phases so the bus is stable before
          // and during the write strobe.
          rd      = aluop;
          load_ac = aluop;
          load_pc = (op == OP_JMP);
          wr      = (op == OP_STO);
          data_e  = (op == OP_STO);
        end
      endcase
    end
  end

  assign phase = phase_q;

endmodule : cpu_controller

// File: tb/tb_cpu_controller.sv
// ----------------------------------------------------------------------------
// tb_cpu_controller
//   Directed bench for cpu_controller with an instruction-level reference
//   model compared on every falling edge, plus literal spot checks.
// ----------------------------------------------------------------------------
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, wr, load_ir, load_pc, inc_pc, load_ac, data_e, halt;
  logic [2:0] phase;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_controller dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .zero    (zero),
    .sel     (sel),
    .rd      (rd),
    .wr      (wr),
    .load_ir (load_ir),
    .load_pc (load_pc),
    .inc_pc  (inc_pc),
    .load_ac (load_ac),
    .data_e  (data_e),
    .halt    (halt),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: instruction-level view of the sequencer.
  // --------------------------------------------------------------------------
  int m_phase  = 0;
  bit m_halted = 1'b0;
  bit m_valid  = 1'b0;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_phase  = 0;
      m_halted = 1'b0;
      m_valid  = 1'b1;
    end else if (m_valid && !m_halted) begin
      if (m_phase == 4 && opcode == 3'd0) m_halted = 1'b1;
      else m_phase = (m_phase + 1) % 8;
    end
  end

  // Expected {sel,rd,wr,load_ir,load_pc,inc_pc,load_ac,data_e,halt}
  function automatic logic [8:0] expect_strobes(input int ph, input bit hlt,
                                                input int op, input bit z);
    bit is_alu, e_sel, e_rd, e_wr, e_ir, e_lpc, e_inc, e_lac, e_de, e_h;
    if (hlt) return 9'b0_0000_0001;
    is_alu = (op >= 2 && op <= 5);
    e_sel  = (ph <= 3);
    e_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && is_alu);
    e_ir   = (ph == 2 || ph == 3);
    e_inc  = (ph == 4 && op != 0) || (ph == 6 && op == 1 && z);
    e_lpc  = (ph >= 6 && op == 7);
    e_de   = (ph >= 6 && op == 6);
    e_wr   = (ph == 7 && op == 6);
    e_lac  = (ph == 7 && is_alu);
    e_h    = (ph == 4 && op == 0);
    return {e_sel, e_rd, e_wr, e_ir, e_lpc, e_inc, e_lac, e_de, e_h};
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_strobes",
            {23'd0, sel, rd, wr, load_ir, load_pc, inc_pc, load_ac, data_e, halt},
            {23'd0, expect_strobes(m_phase, m_halted, int'(opcode), zero)});
      check("model_phase", {29'd0, phase}, m_phase);
      check("inv_ldpc_incpc", {31'd0, load_pc & inc_pc}, 32'd0);
      check("inv_wr_data_e", {31'd0, wr & ~data_e}, 32'd0);
      check("inv_rd_wr", {31'd0, rd & wr}, 32'd0);
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [7:0] rd_tbl, ir_tbl, inc_tbl, lac_tbl, jmp_tbl, skz1_tbl;
    logic [8:0] halted_vec;
    rd_tbl     = 8'b1110_1110;  // bit p = expected value in phase p
    ir_tbl     = 8'b0000_1100;
    inc_tbl    = 8'b0001_0000;
    lac_tbl    = 8'b1000_0000;
    jmp_tbl    = 8'b1100_0000;
    skz1_tbl   = 8'b0101_0000;
    halted_vec = 9'b0_0000_0001;

    rst = 1'b1; opcode = 3'd5; zero = 1'b0;
    tick();
    rst = 1'b0;

    // Reset state: INST_ADDR decode
    check("reset_phase", {29'd0, phase}, 32'd0);
    check("reset_strobes",
          {23'd0, sel, rd, wr, load_ir, load_pc, inc_pc, load_ac, data_e, halt},
          {23'd0, 9'b1_0000_0000});

    // LDA: one full instruction
    for (int p = 0; p < 8; p++) begin
      check("lda_phase",   {29'd0, phase},   p);
      check("lda_rd",      {31'd0, rd},      {31'd0, rd_tbl[p]});
      check("lda_load_ir", {31'd0, load_ir}, {31'd0, ir_tbl[p]});
      check("lda_inc_pc",  {31'd0, inc_pc},  {31'd0, inc_tbl[p]});
      check("lda_load_ac", {31'd0, load_ac}, {31'd0, lac_tbl[p]});
      check("lda_wr_ldpc", {30'd0, wr, load_pc}, 32'd0);
      tick();
    end

    // STO: data_e leads wr by one phase
    opcode = 3'd6;
    ticks(6);
    check("sto_p6_phase", {29'd0, phase}, 32'd6);
    check("sto_p6_de_wr", {30'd0, data_e, wr}, 32'b10);
    tick();
    check("sto_p7_de_wr_rd_lac", {28'd0, data_e, wr, rd, load_ac}, 32'b1100);
    tick();

    // JMP
    opcode = 3'd7;
    for (int p = 0; p < 8; p++) begin
      check("jmp_load_pc", {31'd0, load_pc}, {31'd0, jmp_tbl[p]});
      check("jmp_inc_pc",  {31'd0, inc_pc},  {31'd0, inc_tbl[p]});
      tick();
    end

    // SKZ with zero set, then clear
    opcode = 3'd1; zero = 1'b1;
    for (int p = 0; p < 8; p++) begin
      check("skz_z1_inc_pc", {31'd0, inc_pc}, {31'd0, skz1_tbl[p]});
      tick();
    end
    zero = 1'b0;
    for (int p = 0; p < 8; p++) begin
      check("skz_z0_inc_pc", {31'd0, inc_pc}, {31'd0, inc_tbl[p]});
      tick();
    end

    // HLT: freeze at phase 4 until reset
    opcode = 3'd0;
    ticks(4);
    check("hlt_entry_phase", {29'd0, phase}, 32'd4);
    check("hlt_entry_halt_inc", {30'd0, halt, inc_pc}, 32'b10);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 5)  opcode = 3'd2;
      if (i == 10) zero = 1'b1;
      if (i == 15) opcode = 3'd7;
      check("halted_phase", {29'd0, phase}, 32'd4);
      check("halted_strobes",
            {23'd0, sel, rd, wr, load_ir, load_pc, inc_pc, load_ac, data_e, halt},
            {23'd0, halted_vec});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; zero = 1'b0;
    check("unhalt_phase", {29'd0, phase}, 32'd0);
    check("unhalt_halt_sel", {30'd0, halt, sel}, 32'b01);

    // Reset in STORE of a STO aborts the write
    opcode = 3'd6;
    ticks(7);
    check("sto_pre_reset_wr", {31'd0, wr}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sto_reset_wr", {31'd0, wr}, 32'd0);
    check("sto_reset_phase", {29'd0, phase}, 32'd0);
    for (int p = 1; p <= 3; p++) begin
      tick();
      check("resume_phase", {29'd0, phase}, p);
      check("resume_wr", {31'd0, wr}, 32'd0);
    end

    // Reset mid-execute of an ALU op (phase 5) then sweep non-HLT opcodes
    opcode = 3'd3;
    ticks(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_reset_phase", {29'd0, phase}, 32'd0);
    for (int op = 1; op < 8; op++) begin
      opcode = 3'(op);
      zero   = op[0];
      ticks(8);
      check("sweep_latency_phase", {29'd0, phase}, 32'd0);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cpu_controller
